sram_rd_arbiter: RTL and testbench

SRAM_RD_ARBITER -- requirements
Module: sram_rd_arbiter

---
 rtl/sram_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_sram_rd_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rd_arbiter.sv
// sram_rd_arbiter
// ---------------
// Arbitrates three read requesters (0 = icache, 1 = dcache, 2 = lsu uncached)
// onto a single downstream read channel toward mem2axi. Only one downstream
// read is outstanding at a time. The winner is chosen round-robin, starting
// from the port after the previous winner.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   s_req[2:0]             per-port read request
//   s_addr[0:2]            per-port read address (ADDR_W)
//   s_type[0:2]            per-port access type (TYPE_W), passed through as-is
//   s_rdy[2:0]             per-port request-accepted pulse
//   s_data                 response data shared by all ports (DATA_W)
//   s_valid[2:0]           per-port response-valid pulse
//   m_req/m_addr/m_type    downstream read request
//   m_rdy                  downstream request accept
//   m_data/m_valid         downstream response
module sram_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int TYPE_W = 6,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        s_req,
    input  logic [ADDR_W-1:0] s_addr [0:2],
    input  logic [TYPE_W-1:0] s_type [0:2],
    output logic [2:0]        s_rdy,
    output logic [DATA_W-1:0] s_data,
    output logic [2:0]        s_valid,
    output logic              m_req,
    output logic [ADDR_W-1:0] m_addr,
    output logic [TYPE_W-1:0] m_type,
    input  logic              m_rdy,
    input  logic [DATA_W-1:0] m_data,
    input  logic              m_valid
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]        state;
    logic [1:0]        grant;
    logic [1:0]        last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [TYPE_W-1:0] type_q;

    logic [1:0]        winner;
    logic [ADDR_W-1:0] sel_addr;
    logic [TYPE_W-1:0] sel_type;
    logic [2:0]        grant_mask;

    // Round-robin pick: search starts at the port after last_grant and
    // wraps modulo 3. The result only matters when some s_req is set.
    always_comb begin
        winner = 2'd0;
        case (last_grant)
            2'd0: begin
                if (s_req[1])      winner = 2'd1;
                else if (s_req[2]) winner = 2'd2;
                else               winner = 2'd0;
            end
            2'd1: begin
                if (s_req[2])      winner = 2'd2;
                else if (s_req[0]) winner = 2'd0;
                else               winner = 2'd1;
            end
            default: begin
                if (s_req[0])      winner = 2'd0;
                else if (s_req[1]) winner = 2'd1;
                else               winner = 2'd2;
            end
        endcase
    end

    always_comb begin
        sel_addr = s_addr[0];
        sel_type = s_type[0];
        case (winner)
            2'd1: begin
                sel_addr = s_addr[1];
                sel_type = s_type[1];
            end
            2'd2: begin
                sel_addr = s_addr[2];
                sel_type = s_type[2];
            end
            default: begin
                sel_addr = s_addr[0];
                sel_type = s_type[0];
            end
        endcase
    end

    // last_grant resets to 2 so that port 0 is first in line after reset.
    // Any unreachable state encoding falls back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd2;
            addr_q     <= '0;
            type_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_req) begin
                        grant      <= winner;
                        last_grant <= winner;
                        addr_q     <= sel_addr;
                        type_q     <= sel_type;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (m_rdy) state <= WAIT;
                end
                WAIT: begin
                    if (m_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (grant)
            2'd0:    grant_mask = 3'b001;
            2'd1:    grant_mask = 3'b010;
            2'd2:    grant_mask = 3'b100;
            default: grant_mask = 3'b000;
        endcase
    end

    // Handshake outputs are gated by state so that m_rdy outside REQ and
    // m_valid outside WAIT have no visible effect.
    assign m_req   = (state == REQ);
    assign m_addr  = addr_q;
    assign m_type  = type_q;
    assign s_rdy   = (state == REQ  && m_rdy)   ? grant_mask : 3'b000;
    assign s_valid = (state == WAIT && m_valid) ? grant_mask : 3'b000;
    assign s_data  = m_data;

endmodule

// File: tb/tb_sram_rd_arbiter.sv
// Directed testbench for sram_rd_arbiter.
module tb_sram_rd_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   s_req;
    logic [31:0]  s_addr [0:2];
    logic [5:0]   s_type [0:2];
    logic [2:0]   s_rdy;
    logic [255:0] s_data;
    logic [2:0]   s_valid;
    logic         m_req;
    logic [31:0]  m_addr;
    logic [5:0]   m_type;
    logic         m_rdy;
    logic [255:0] m_data;
    logic         m_valid;

    int checks   = 0;
    int failures = 0;

    sram_rd_arbiter #(.ADDR_W(32), .TYPE_W(6), .DATA_W(256)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_req   (s_req),
        .s_addr  (s_addr),
        .s_type  (s_type),
        .s_rdy   (s_rdy),
        .s_data  (s_data),
        .s_valid (s_valid),
        .m_req   (m_req),
        .m_addr  (m_addr),
        .m_type  (m_type),
        .m_rdy   (m_rdy),
        .m_data  (m_data),
        .m_valid (m_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_req   = 3'b000;
        m_rdy   = 1'b0;
        m_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_req   = 3'b111;
        m_rdy   = 1'b1;
        m_valid = 1'b1;
        m_data  = {8{32'hA5A5_0001}};
        for (int i = 0; i < 3; i++) begin
            s_addr[i] = 32'h1000_0000 + 32'(i * 16);
            s_type[i] = 6'(i + 1);
        end
        tick();
        #1;
        checks++;
        if (m_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mreq got=%0h exp=0", m_req);
        end
        checks++;
        if (s_rdy !== 3'b000 || s_valid !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_handshake got=%b/%b exp=000/000", s_rdy, s_valid);
        end
        checks++;
        if (m_addr !== 32'h0 || m_type !== 6'h0) begin
            failures++;
            $display("[TB] FAIL reset_latched got=%h/%h exp=0/0", m_addr, m_type);
        end
        checks++;
        if (s_data !== {8{32'hA5A5_0001}}) begin
            failures++;
            $display("[TB] FAIL reset_sdata got=%h exp=%h", s_data, {8{32'hA5A5_0001}});
        end
        s_req   = 3'b000;
        m_rdy   = 1'b0;
        m_valid = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [255:0] pat;
        pat = {8{32'hCAFE_0040}};
        s_req     = 3'b010;
        s_addr[1] = 32'h8000_0040;
        s_type[1] = 6'h15;
        m_rdy     = 1'b1;
        #1;
        checks++;
        if (m_req !== 1'b0 || s_rdy !== 3'b000) begin
            failures++;
            $display("[TB] FAIL single_idle got=%b/%b exp=0/000", m_req, s_rdy);
        end
        tick();
        #1;
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h8000_0040 || m_type !== 6'h15) begin
            failures++;
            $display("[TB] FAIL single_mreq got=%b/%h/%h exp=1/80000040/15", m_req, m_addr, m_type);
        end
        checks++;
        if (s_rdy !== 3'b010) begin
            failures++;
            $display("[TB] FAIL single_srdy got=%b exp=010", s_rdy);
        end
        tick();
        s_req = 3'b000;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (s_valid !== 3'b000 || s_rdy !== 3'b000 || m_req !== 1'b0) begin
                failures++;
                $display("[TB] FAIL single_wait got=%b/%b/%b exp=000/000/0", s_valid, s_rdy, m_req);
            end
            tick();
        end
        m_valid = 1'b1;
        m_data  = pat;
        #1;
        checks++;
        if (s_valid !== 3'b010 || s_data !== pat) begin
            failures++;
            $display("[TB] FAIL single_svalid got=%b/%h exp=010/%h", s_valid, s_data, pat);
        end
        tick();
        m_valid = 1'b0;
        #1;
        checks++;
        if (s_valid !== 3'b000 || m_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_after got=%b/%b exp=000/0", s_valid, m_req);
        end
    endtask

    task automatic test_round_robin();
        int order [0:3];
        order = '{0, 1, 2, 0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s_addr[i] = 32'h2000_0000 + 32'(i * 32'h100);
            s_type[i] = 6'(8 + i);
        end
        m_rdy = 1'b1;
        for (int t = 0; t < 4; t++) begin
            m_valid = 1'b0;
            s_req   = 3'b111;
            #1;
            checks++;
            if (m_req !== 1'b0 || s_rdy !== 3'b000) begin
                failures++;
                $display("[TB] FAIL rr_idle%0d got=%b/%b exp=0/000", t, m_req, s_rdy);
            end
            tick();
            #1;
            checks++;
            if (s_rdy !== (3'b001 << order[t]) ||
                m_addr !== 32'h2000_0000 + 32'(order[t] * 32'h100) ||
                m_type !== 6'(8 + order[t])) begin
                failures++;
                $display("[TB] FAIL rr_grant%0d got=%b/%h/%h exp=%b/%h/%h", t, s_rdy, m_addr, m_type,
                         3'b001 << order[t], 32'h2000_0000 + 32'(order[t] * 32'h100), 6'(8 + order[t]));
            end
            tick();
            m_valid = 1'b1;
            m_data  = {8{32'h0000_0100 + 32'(t)}};
            #1;
            checks++;
            if (s_valid !== (3'b001 << order[t]) || s_rdy !== 3'b000) begin
                failures++;
                $display("[TB] FAIL rr_valid%0d got=%b/%b exp=%b/000", t, s_valid, s_rdy, 3'b001 << order[t]);
            end
            tick();
        end
        m_valid = 1'b0;
        s_req   = 3'b000;
        tick();
    endtask

    task automatic test_backpressure();
        // last_grant is 0 here; port 2 requests alone.
        s_req     = 3'b100;
        s_addr[2] = 32'h3333_0000;
        s_type[2] = 6'h2A;
        m_rdy     = 1'b0;
        tick();
        s_addr[2] = 32'hFFFF_FFFF;
        s_type[2] = 6'h01;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (m_req !== 1'b1 || m_addr !== 32'h3333_0000 || m_type !== 6'h2A || s_rdy !== 3'b000) begin
                failures++;
                $display("[TB] FAIL bp_hold%0d got=%b/%h/%h/%b exp=1/33330000/2a/000", i, m_req, m_addr, m_type, s_rdy);
            end
            tick();
        end
        m_rdy = 1'b1;
        #1;
        checks++;
        if (s_rdy !== 3'b100 || m_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_accept got=%b/%b exp=100/1", s_rdy, m_req);
        end
        tick();
        s_req   = 3'b000;
        m_rdy   = 1'b0;
        m_valid = 1'b1;
        #1;
        checks++;
        if (s_valid !== 3'b100) begin
            failures++;
            $display("[TB] FAIL bp_valid got=%b exp=100", s_valid);
        end
        tick();
        m_valid = 1'b0;
    endtask

    task automatic test_abandon();
        s_req     = 3'b100;
        s_addr[2] = 32'h4444_0080;
        m_rdy     = 1'b1;
        tick();
        s_req = 3'b000;
        #1;
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'h4444_0080 || s_rdy !== 3'b100) begin
            failures++;
            $display("[TB] FAIL abandon_req got=%b/%h/%b exp=1/44440080/100", m_req, m_addr, s_rdy);
        end
        tick();
        m_valid = 1'b1;
        #1;
        checks++;
        if (s_valid !== 3'b100) begin
            failures++;
            $display("[TB] FAIL abandon_valid got=%b exp=100", s_valid);
        end
        tick();
        m_valid = 1'b0;
        #1;
        checks++;
        if (s_valid !== 3'b000 || m_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abandon_after got=%b/%b exp=000/0", s_valid, m_req);
        end
    endtask

    task automatic test_spurious();
        s_req   = 3'b000;
        m_rdy   = 1'b1;
        m_valid = 1'b1;
        #1;
        checks++;
        if (s_valid !== 3'b000 || s_rdy !== 3'b000 || m_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL spur_idle got=%b/%b/%b exp=000/000/0", s_valid, s_rdy, m_req);
        end
        tick();
        #1;
        checks++;
        if (m_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL spur_idle_hold got=%b exp=0", m_req);
        end
        m_valid   = 1'b0;
        m_rdy     = 1'b0;
        s_req     = 3'b001;
        s_addr[0] = 32'h5555_0000;
        tick();
        s_req   = 3'b000;
        m_valid = 1'b1;
        #1;
        checks++;
        if (s_valid !== 3'b000 || m_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL spur_req got=%b/%b exp=000/1", s_valid, m_req);
        end
        tick();
        m_valid = 1'b0;
        m_rdy   = 1'b1;
        #1;
        checks++;
        if (m_req !== 1'b1 || s_rdy !== 3'b001 || m_addr !== 32'h5555_0000) begin
            failures++;
            $display("[TB] FAIL spur_req_hold got=%b/%b/%h exp=1/001/55550000", m_req, s_rdy, m_addr);
        end
        tick();
        m_rdy   = 1'b0;
        m_valid = 1'b1;
        #1;
        checks++;
        if (s_valid !== 3'b001) begin
            failures++;
            $display("[TB] FAIL spur_valid got=%b exp=001", s_valid);
        end
        tick();
        m_valid = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        // last_grant is 0 here; port 1 wins.
        s_req     = 3'b010;
        s_addr[1] = 32'h6666_0000;
        m_rdy     = 1'b1;
        tick();
        s_req = 3'b000;
        #1;
        checks++;
        if (s_rdy !== 3'b010) begin
            failures++;
            $display("[TB] FAIL rw_accept got=%b exp=010", s_rdy);
        end
        tick();
        m_rdy   = 1'b0;
        rst_n   = 1'b0;
        m_valid = 1'b1;
        #1;
        checks++;
        if (s_valid !== 3'b000 || m_req !== 1'b0 || m_addr !== 32'h0) begin
            failures++;
            $display("[TB] FAIL rw_in_reset got=%b/%b/%h exp=000/0/0", s_valid, m_req, m_addr);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_valid !== 3'b000) begin
            failures++;
            $display("[TB] FAIL rw_late_valid got=%b exp=000", s_valid);
        end
        tick();
        m_valid   = 1'b0;
        s_req     = 3'b110;
        s_addr[1] = 32'h7777_0010;
        s_addr[2] = 32'h7777_0020;
        m_rdy     = 1'b1;
        tick();
        #1;
        checks++;
        if (s_rdy !== 3'b010 || m_addr !== 32'h7777_0010) begin
            failures++;
            $display("[TB] FAIL rw_next_grant got=%b/%h exp=010/77770010", s_rdy, m_addr);
        end
        tick();
        s_req   = 3'b000;
        m_valid = 1'b1;
        #1;
        checks++;
        if (s_valid !== 3'b010) begin
            failures++;
            $display("[TB] FAIL rw_next_valid got=%b exp=010", s_valid);
        end
        tick();
        m_valid = 1'b0;
    endtask

    initial begin
        m_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_abandon();
        test_spurious();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
